uart_rx_ext: RTL

Parametrised successor to the existing 8N1 UART receiver. Adds configurable payload width, optional odd/even parity, 1 or 2 stop bits, 3-sample majority-vote bit sampling, start-bit glitch rejection, per-frame error flags, and a valid/ready output handshake with overrun detection. It sits between the uart_rxd pin and the host-side byte consumer, in place of the current receiver.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_sampler.sv | 61 ++++++
 rtl/uart_rx_ext.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding, bit-period helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Clock cycles per line bit, truncated.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line front end: 2-flop synchroniser, free-running bit timer restartable by the
// FSM, and a 3-sample majority vote around the middle of each bit period.
module uart_bit_sampler #(
  parameter int CPB = 434
) (
  input  logic clk,
  input  logic resetn,
  input  logic rxd,
  input  logic restart,
  output logic rxd_sync,
  output logic sample_strobe,
  output logic bit_val
);

  localparam int TMR_W = $clog2(CPB);
  localparam int MID   = CPB / 2;

  logic             sync_p0;
  logic             sync_p1;
  logic [TMR_W-1:0] timer;
  logic             samp_a;
  logic             samp_b;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchroniser; resets to the idle (high) line level so no false start after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rxd;
      sync_p1 <= sync_p0;
    end
  end

  assign rxd_sync = sync_p1;

  // Bit timer: 0..CPB-1, held at zero while the FSM requests a restart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (restart || (timer == TMR_W'(CPB - 1))) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Capture the first two of the three mid-bit samples; the third is the live line.
  always_ff @(posedge clk) begin
    if (timer == TMR_W'(MID - 1)) samp_a <= rxd_sync;
    if (timer == TMR_W'(MID))     samp_b <= rxd_sync;
  end

  assign sample_strobe = !restart && (timer == TMR_W'(MID + 1));
  assign bit_val       = majority3(samp_a, samp_b, rxd_sync);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: configurable payload, optional parity, 1/2 stop bits,
// majority-vote sampling, glitch rejection, break detection, valid/ready output
// with sticky overrun.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  input  logic                    uart_rx_ready,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_parity_err,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_overrun,
  output logic                    uart_rx_break
);

  localparam int   CPB         = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int   CNT_W       = $clog2(PAYLOAD_BITS);
  localparam logic PAR_ODD_EXP = (PARITY == PARITY_ODD);
  localparam logic STOP_LAST   = (STOP_BITS == 2);

  rx_state_t               state;
  rx_state_t               state_nxt;
  logic                    restart;
  logic                    rxd_sync;
  logic                    strobe;
  logic                    bit_val;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    stop_cnt;
  logic [PAYLOAD_BITS-1:0] rx_shift;
  logic                    par_acc;
  logic                    par_err;
  logic                    frm_err_acc;
  logic                    zero_acc;
  logic                    frame_done;
  logic                    frame_brk;
  logic                    done_ferr;
  logic                    done_ok;
  logic                    handshake;

  uart_bit_sampler #(
    .CPB(CPB)
  ) u_sampler (
    .clk          (clk),
    .resetn       (resetn),
    .rxd          (uart_rxd),
    .restart      (restart),
    .rxd_sync     (rxd_sync),
    .sample_strobe(strobe),
    .bit_val      (bit_val)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state, timer restart and frame-completion decode.
  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    frame_done = 1'b0;
    frame_brk  = 1'b0;
    done_ferr  = frm_err_acc | ~bit_val;
    unique case (state)
      ST_IDLE: begin
        restart = 1'b1;
        if (!rxd_sync) state_nxt = ST_START;
      end
      ST_START: begin
        if (strobe) state_nxt = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (strobe && (bit_cnt == CNT_W'(PAYLOAD_BITS - 1)))
          state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (strobe) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (strobe && (stop_cnt == STOP_LAST)) begin
          frame_done = 1'b1;
          // Break needs the first stop bit low; with two stop bits it was folded in already.
          frame_brk  = (stop_cnt == 1'b0) ? (zero_acc & ~bit_val) : zero_acc;
          state_nxt  = bit_val ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxd_sync) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Disabling the receiver abandons any partial frame.
    if (!uart_rx_en) begin
      state_nxt  = ST_IDLE;
      restart    = 1'b1;
      frame_done = 1'b0;
      frame_brk  = 1'b0;
    end
  end

  // Bit and stop counters, cleared outside their own states.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      if (state != ST_DATA)  bit_cnt <= '0;
      else if (strobe)       bit_cnt <= bit_cnt + CNT_W'(1);
      if (state != ST_STOP)  stop_cnt <= 1'b0;
      else if (strobe)       stop_cnt <= ~stop_cnt;
    end
  end

  // Frame datapath: LSB-first shift, running parity, error and break accumulators.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      par_acc     <= 1'b0;
      par_err     <= 1'b0;
      frm_err_acc <= 1'b0;
      zero_acc    <= 1'b1;
    end else if (strobe) begin
      case (state)
        ST_DATA: begin
          rx_shift <= {bit_val, rx_shift[PAYLOAD_BITS-1:1]};
          par_acc  <= par_acc ^ bit_val;
          zero_acc <= zero_acc & ~bit_val;
        end
        ST_PARITY: begin
          par_err  <= (par_acc ^ bit_val) != PAR_ODD_EXP;
          zero_acc <= zero_acc & ~bit_val;
        end
        ST_STOP: begin
          frm_err_acc <= frm_err_acc | ~bit_val;
          if (stop_cnt == 1'b0) zero_acc <= zero_acc & ~bit_val;
        end
        default: ;
      endcase
    end
  end

  assign done_ok   = frame_done & ~frame_brk;
  assign handshake = uart_rx_valid & uart_rx_ready;

  // Output holding register with valid/ready handshake, sticky overrun, break pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_rx_valid      <= 1'b0;
      uart_rx_data       <= '0;
      uart_rx_parity_err <= 1'b0;
      uart_rx_frame_err  <= 1'b0;
      uart_rx_overrun    <= 1'b0;
      uart_rx_break      <= 1'b0;
    end else begin
      uart_rx_break <= frame_done & frame_brk;
      if (done_ok && (!uart_rx_valid || handshake)) begin
        uart_rx_valid      <= 1'b1;
        uart_rx_data       <= rx_shift;
        uart_rx_parity_err <= par_err;
        uart_rx_frame_err  <= done_ferr;
        uart_rx_overrun    <= 1'b0;
      end else if (done_ok) begin
        uart_rx_overrun <= 1'b1;
      end else if (handshake) begin
        uart_rx_valid   <= 1'b0;
        uart_rx_overrun <= 1'b0;
      end
    end
  end

endmodule
